vga_line_fetch: RTL and testbench
=================================

// Module: vga_line_fetch
// PURPOSE
// Pixel source that sits directly upstream of the 640x480@60 VGA controller and drives its inRed/inGreen/inBlue.
// It fetches a 320x240, 8-bit-per-pixel framebuffer from external memory one source row at a time,
// through a single-outstanding req/valid handshake, into a ping-pong line buffer.
// It doubles every source row and every source pixel horizontally and vertically, and expands the index to 24-bit RGB.
// PARAMETERS
// H_SRC      320  source pixels per row (display width / 2)
// V_SRC      240  source rows per frame (display height / 2)
// BASE_ADDR  0    memory address of source pixel (0,0); 17-bit
// PORTS
// clk25          in   1   pixel clock, 25 MHz
// rstN           in   1   reset: synchronous, active-low
// inX            in   10  display x from controller outX (0..639)
// inY            in   10  display y from controller outY (0..479)
// inRequest      in   1   controller outRequest (display-active)
// outRed         out  8   red to controller inRed
// outGreen       out  8   green to controller inGreen
// outBlue        out  8   blue to controller inBlue
// memReq         out  1   read request, registered
// memAddr        out  17  read address, registered, stable while memReq=1
// memValid       in   1   read data valid, completes current request
// memData        in   8   read data, sampled when memValid=1
// fetchOverrun   out  1   sticky: a fetch trigger arrived while a fetch was busy
// BEHAVIOUR
// - Reset (rstN=0 at posedge): FSM=IDLE, memReq=0, memAddr=0, fetchOverrun=0, edge-detect flop=0.
//   While rstN=0, outRed/outGreen/outBlue are forced to 0. Line-buffer contents are not cleared.
//   The first frame after reset may show stale data.
// - Line buffer: 2 banks x H_SRC x 8 bits, asynchronous read. Source row r is stored in bank r[0].
// - Display path (combinational, 0 latency, same cycle as inX/inY):
//   - idx = bank[inY[1]][inX[9:1]].
//   - RGB = expand(idx) when inRequest=1, else 24'h0.
// - RGB332 expansion of idx = {r[2:0], g[2:0], b[1:0]}:
//   - R = {r,r,r[2:1]}
//   - G = {g,g,g[2:1]}
//   - B = {b,b,b,b}
// - Fetch triggers, evaluated on the registered previous inRequest:
//   - T_FRAME: inRequest falls (1->0) with inY==479. Fetches row 0.
//   - T_LINE: inRequest rises (0->1) with inY[0]==0 and (inY>>1)+1 < V_SRC. Fetches row (inY>>1)+1.
// - FSM:
//   - IDLE: a trigger goes to REQ, sets col=0 and addr=BASE_ADDR+row*320 (row*320 = (row<<8)+(row<<6)), and sets memReq=1.
//   - REQ: memReq=1, memAddr held. On memValid=1:
//     - write memData into bank[row[0]][col].
//     - if col==H_SRC-1: memReq=0 and go to IDLE (no extra cycle).
//     - else col++, memAddr++, memReq stays 1 (back-to-back allowed).
//   - A trigger arriving in REQ sets fetchOverrun=1, abandons the current row, and restarts at the new row's base address the next cycle.
//   - memValid while IDLE is ignored.
// - Timing budget: one row fetch must finish within 2 display lines (1600 clk). Memory latency up to 4 clk per read is guaranteed to meet this.
// - Bank hazard: a row fetch never writes the bank being displayed. Row k+1 is written while rows 2k and 2k+1 show bank k[0].
// - Reset mid-fetch: memReq drops at the reset edge. The partially written row stays partially written.
// CONFIGURATION
// PALETTE_RAM_EN defined:
//   - Adds ports palWe (in 1), palAddr (in 8), palData (in 24, {R,G,B}).
//   - Adds a 256x24 palette RAM: written on posedge when palWe=1, read asynchronously with idx; replaces the RGB332 expansion.
//   - A write is visible from the next cycle. Palette contents are not reset.
// PALETTE_RAM_EN undefined:
//   - No palette ports; fixed RGB332 expansion.
// TESTING
// 1. rstN=0 for 10 clk, inRequest=1 -> memReq=0, memAddr=0, RGB=0, fetchOverrun=0.
// 2. inRequest 1->0 at inY=479; memory model latency 2 clk -> memReq=1 next clk; addresses 0..319 issued once each, in order; then memReq=0.
// 3. Memory returns addr[7:0]; inY=0, inRequest=1, inX=2 and inX=3 -> idx 8'h01 -> R=00, G=00, B=55 both cycles; inRequest=0 -> RGB=0.
// 4. inRequest 0->1 at inY=2 -> fetch row 2, addresses 640..959 into bank 0; inY=478 rise -> no fetch.
// 5. Memory latency 10 clk -> second trigger mid-fetch -> fetchOverrun=1 and stays 1; next memAddr = new row base.
// 6. PALETTE_RAM_EN defined: palWe, palAddr=8'h01, palData=24'h123456 -> pixel idx 01 shows R=12, G=34, B=56.

Source files
------------

// File: rtl/vga_line_fetch_if.sv
// Single-outstanding memory read port of the VGA line fetcher: memReq/memAddr held until memValid returns memData.
// The fetcher is the master; the external memory (or its model) is the slave.
interface vga_line_fetch_if;
   logic        memReq;
   logic [16:0] memAddr;
   logic        memValid;
   logic [7:0]  memData;

   modport master (output memReq, output memAddr, input memValid, input memData);
   modport slave  (input memReq, input memAddr, output memValid, output memData);
endinterface

// File: rtl/vga_line_fetch.sv
// Line-doubling 320x240 8bpp pixel source for a 640x480 VGA controller; PALETTE_RAM_EN swaps RGB332 for a palette RAM.
// Pixel path 0 clk (combinational); memory side one read in flight, memReq/memAddr held until memValid.
module vga_line_fetch #(
   parameter int          H_SRC     = 320,
   parameter int          V_SRC     = 240,
   parameter logic [16:0] BASE_ADDR = 17'd0
) (
   input  logic                    clk25,
   input  logic                    rstN,
   input  logic [9:0]              inX,
   input  logic [9:0]              inY,
   input  logic                    inRequest,
   output logic [7:0]              outRed,
   output logic [7:0]              outGreen,
   output logic [7:0]              outBlue,
   vga_line_fetch_if.master        mem,
`ifdef PALETTE_RAM_EN
   input  logic                    palWe,
   input  logic [7:0]              palAddr,
   input  logic [23:0]             palData,
`endif
   output logic                    fetchOverrun
);
   localparam int COL_W = $clog2(H_SRC);
   localparam int ROW_W = $clog2(V_SRC);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   logic [0:0]       state;
   logic             reqPrev;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             memReq;
   logic [16:0]      memAddr;
   logic [7:0]       lineBuf [2][H_SRC];

   logic [9:0]       nextRow;
   logic             tFrame;
   logic             tLine;
   logic             trigger;
   logic [ROW_W-1:0] trigRow;
   logic [16:0]      trigBase;
   logic             bufWe;
   logic [7:0]       idx;
   logic [23:0]      color;
   logic             unusedInX0;

   assign unusedInX0 = inX[0];

   // Triggers compare the live inRequest against last cycle's to find its edges.
   assign nextRow  = {1'b0, inY[9:1]} + 10'd1;
   assign tFrame   = reqPrev && !inRequest && (inY == 10'(2 * V_SRC - 1));
   assign tLine    = !reqPrev && inRequest && !inY[0] && (nextRow < 10'(V_SRC));
   assign trigger  = tFrame || tLine;
   assign trigRow  = tFrame ? '0 : nextRow[ROW_W-1:0];
   assign trigBase = BASE_ADDR + 17'(trigRow) * 17'(H_SRC);

   always_ff @(posedge clk25) begin
      if (!rstN) begin
         state        <= IDLE;
         reqPrev      <= 1'b0;
         memReq       <= 1'b0;
         memAddr      <= '0;
         fetchOverrun <= 1'b0;
         col          <= '0;
         row          <= '0;
      end else begin
         reqPrev <= inRequest;
         if (trigger) begin
            // A new trigger always wins; a fetch still in progress is abandoned.
            if (state == REQ) fetchOverrun <= 1'b1;
            state   <= REQ;
            memReq  <= 1'b1;
            memAddr <= trigBase;
            col     <= '0;
            row     <= trigRow;
         end else if (state == REQ && mem.memValid) begin
            if (col == COL_W'(H_SRC - 1)) begin
               state  <= IDLE;
               memReq <= 1'b0;
            end else begin
               col     <= col + COL_W'(1);
               memAddr <= memAddr + 17'd1;
            end
         end
      end
   end

   assign mem.memReq  = memReq;
   assign mem.memAddr = memAddr;

   // Data returning in a trigger cycle belongs to the abandoned row and is dropped.
   assign bufWe = rstN && (state == REQ) && mem.memValid && !trigger;

   always_ff @(posedge clk25) begin
      if (bufWe) lineBuf[row[0]][col] <= mem.memData;
   end

   assign idx = lineBuf[inY[1]][inX[9:1]];

`ifdef PALETTE_RAM_EN
   logic [23:0] palRam [256];

   always_ff @(posedge clk25) begin
      if (palWe) palRam[palAddr] <= palData;
   end

   assign color = palRam[idx];
`else
   assign color = {idx[7:5], idx[7:5], idx[7:6],
                   idx[4:2], idx[4:2], idx[4:3],
                   {4{idx[1:0]}}};
`endif

   assign {outRed, outGreen, outBlue} = (rstN && inRequest) ? color : 24'h0;
endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized scoreboard bench for vga_line_fetch: memory responder, row-level display model, address and pixel monitors.
// Build with PALETTE_RAM_EN defined to exercise the palette variant.
module tb_vga_line_fetch;
   localparam int H = 320;
   localparam int V = 240;

   logic        clk25 = 1'b0;
   logic        rstN;
   logic [9:0]  inX;
   logic [9:0]  inY;
   logic        inRequest;
   logic [7:0]  outRed;
   logic [7:0]  outGreen;
   logic [7:0]  outBlue;
   logic        fetchOverrun;
`ifdef PALETTE_RAM_EN
   logic        palWe;
   logic [7:0]  palAddr;
   logic [23:0] palData;
   logic [23:0] palModel [256];
`endif

   vga_line_fetch_if mif ();

   logic        respValid;
   logic [7:0]  respData;
   logic        spurValid;
   logic        pixStrobe;
   int          memLat;

   assign mif.memValid = respValid | spurValid;
   assign mif.memData  = spurValid ? 8'hA5 : respData;

   always #20 clk25 = ~clk25;

   vga_line_fetch dut (
      .clk25        (clk25),
      .rstN         (rstN),
      .inX          (inX),
      .inY          (inY),
      .inRequest    (inRequest),
      .outRed       (outRed),
      .outGreen     (outGreen),
      .outBlue      (outBlue),
      .mem          (mif),
`ifdef PALETTE_RAM_EN
      .palWe        (palWe),
      .palAddr      (palAddr),
      .palData      (palData),
`endif
      .fetchOverrun (fetchOverrun)
   );

   // Reference state: memory image, and per bank which complete source row it holds.
   logic [7:0]  memImg   [H * V];
   logic [7:0]  bankData [2][H];
   logic [7:0]  pendData [H];
   int          bankRow  [2];
   int unsigned expAddrQ [$];
   logic [23:0] pixQ     [$];
   int          nChecks = 0;
   int          nPass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   function automatic logic [23:0] refColor(input logic [7:0] i);
`ifdef PALETTE_RAM_EN
      return palModel[i];
`else
      int r, g, b, rr, gg, bb;
      r  = i >> 5;
      g  = (i >> 2) & 7;
      b  = i & 3;
      rr = (r << 5) | (r << 2) | (r >> 1);
      gg = (g << 5) | (g << 2) | (g >> 1);
      bb = b * 85;
      return {rr[7:0], gg[7:0], bb[7:0]};
`endif
   endfunction

   // Memory slave: answers the held request memLat clocks later with the byte at the then-current address.
   initial begin
      respValid = 1'b0;
      respData  = 8'h00;
      forever begin
         @(posedge clk25); #1;
         respValid = 1'b0;
         if (rstN && mif.memReq) begin
            for (int k = 1; k < memLat; k++) begin @(posedge clk25); #1; end
            if (rstN && mif.memReq) begin
               respValid = 1'b1;
               respData  = memImg[mif.memAddr];
            end
         end
      end
   end

   always @(negedge clk25) begin
      if (rstN && mif.memReq && mif.memValid && !spurValid) begin
         if (expAddrQ.size() == 0) begin
            nChecks++;
            $display("FAIL addrSeq: read of address %0d, required none", mif.memAddr);
         end else begin
            check("addrSeq", 32'(mif.memAddr), expAddrQ.pop_front());
         end
      end
      if (pixStrobe && pixQ.size() != 0) check("pixel", {8'h00, outRed, outGreen, outBlue}, {8'h00, pixQ.pop_front()});
   end

   task automatic tick();
      @(posedge clk25); #2;
      pixStrobe = 1'b0;
   endtask

   task automatic startFetch(input int r);
      expAddrQ.delete();
      for (int i = 0; i < H; i++) begin
         expAddrQ.push_back(r * H + i);
         pendData[i] = memImg[r * H + i];
      end
      bankRow[r % 2] = -1;
   endtask

   task automatic waitFetchDone(input int r, input int bound);
      int n;
      n = 0;
      while (mif.memReq === 1'b1 && n < bound) begin tick(); n++; end
      if (mif.memReq !== 1'b0) begin
         nChecks++;
         $display("FAIL fetchTimeout: memReq=%b after %0d clk, required 0", mif.memReq, bound);
      end else begin
         check("addrQueueDrained", expAddrQ.size(), 0);
         for (int i = 0; i < H; i++) bankData[r % 2][i] = pendData[i];
         bankRow[r % 2] = r;
      end
   endtask

   task automatic frameTrigger();
      tick(); inY = 10'd479; inRequest = 1'b1;
      tick(); inRequest = 1'b0;
      tick();
   endtask

   task automatic lineTrigger(input int y);
      tick(); inY = 10'(y); inRequest = 1'b0;
      tick(); inRequest = 1'b1;
      tick();
   endtask

   task automatic enterDisplay(input int oddY);
      tick(); inY = 10'(oddY); inRequest = 1'b1;
   endtask

   task automatic showPixel(input int x, input int y);
      int b;
      logic [23:0] e;
      bit known;
      tick();
      inX   = 10'(x);
      inY   = 10'(y);
      b     = (y >> 1) & 1;
      known = 1'b1;
      e     = 24'h0;
      if (!inRequest) e = 24'h0;
      else if (bankRow[b] == (y >> 1)) e = refColor(bankData[b][x >> 1]);
      else known = 1'b0;
      if (known) begin pixQ.push_back(e); pixStrobe = 1'b1; end
   endtask

   task automatic randomPixels(input int n);
      int b, y;
      for (int i = 0; i < n; i++) begin
         b = $urandom_range(0, 1);
         if (bankRow[b] >= 0) begin
            y = 2 * bankRow[b] + $urandom_range(0, 1);
            showPixel($urandom_range(0, 639), y);
         end
      end
   endtask

   initial begin
      rstN = 1'b0; inRequest = 1'b1; inX = '0; inY = 10'd5;
      spurValid = 1'b0; pixStrobe = 1'b0; memLat = 2;
`ifdef PALETTE_RAM_EN
      palWe = 1'b0; palAddr = '0; palData = '0;
`endif
      for (int a = 0; a < H * V; a++) memImg[a] = a[7:0];
      bankRow[0] = -1;
      bankRow[1] = -1;

      // Reset with the display active: everything idle and black.
      repeat (10) tick();
      check("rstMemReq", mif.memReq, 0);
      check("rstMemAddr", 32'(mif.memAddr), 0);
      check("rstRGB", {8'h00, outRed, outGreen, outBlue}, 0);
      check("rstOverrun", fetchOverrun, 0);
      rstN = 1'b1;
      tick();

`ifdef PALETTE_RAM_EN
      for (int i = 0; i < 256; i++) begin
         palWe = 1'b1; palAddr = 8'(i);
         palData = (i == 1) ? 24'h123456 : 24'($urandom);
         palModel[i] = palData;
         tick();
      end
      palWe = 1'b0;
`endif

      // End-of-frame trigger fetches row 0 with 2-clk memory.
      startFetch(0);
      frameTrigger();
      check("frameReqRise", mif.memReq, 1);
      check("frameFirstAddr", 32'(mif.memAddr), 0);
      waitFetchDone(0, 2000);

      // Row 0 holds addr[7:0]: display x=2,3 on line 0 show index 01.
      enterDisplay(1);
      for (int x = 2; x <= 3; x++) begin
         showPixel(x, 0);
         #1;
`ifdef PALETTE_RAM_EN
         check("palettePixel", {8'h00, outRed, outGreen, outBlue}, 32'h00123456);
`else
         check("specPixRG", {16'h0, outRed, outGreen}, 0);
         check("specPixB", outBlue, 8'h55);
`endif
      end
      tick(); inRequest = 1'b0;
      showPixel(2, 0);

      // Line trigger on even line 2 fetches row 2 into bank 0.
      startFetch(2);
      lineTrigger(2);
      check("lineReqRise", mif.memReq, 1);
      check("lineFirstAddr", 32'(mif.memAddr), 640);
      waitFetchDone(2, 2000);

      // Last even line has no following row; stray memValid while idle is ignored.
      lineTrigger(478);
      repeat (4) tick();
      check("noFetchAt478", mif.memReq, 0);
      tick(); spurValid = 1'b1;
      tick(); spurValid = 1'b0;
      enterDisplay(5);
      showPixel(638, 4);
      showPixel(639, 5);
      randomPixels(6);

      // Random rows, random image, random memory latency 1..4.
      for (int a = 0; a < H * V; a++) memImg[a] = 8'($urandom);
      for (int it = 0; it < 5; it++) begin
         int r;
         memLat = $urandom_range(1, 4);
         r = $urandom_range(1, V - 1);
         startFetch(r);
         lineTrigger(2 * (r - 1));
         waitFetchDone(r, 2000);
         enterDisplay(2 * r + 1);
         randomPixels(8);
      end

      // Reset in the middle of a fetch drops memReq at the reset edge.
      startFetch(6);
      lineTrigger(10);
      repeat (20) tick();
      rstN = 1'b0; inY = 10'd11;
      tick();
      check("midResetMemReq", mif.memReq, 0);
      check("midResetRGB", {8'h00, outRed, outGreen, outBlue}, 0);
      expAddrQ.delete();
      bankRow[0] = -1;
      rstN = 1'b1;
      repeat (3) tick();
      check("postResetIdle", mif.memReq, 0);
      check("postResetOverrun", fetchOverrun, 0);

      // Slow memory: second trigger mid-fetch restarts at the new row and sets the sticky flag.
      memLat = 10;
      startFetch(2);
      lineTrigger(2);
      repeat (3) tick();
      check("overrunBefore", fetchOverrun, 0);
      startFetch(3);
      lineTrigger(4);
      check("overrunRestartAddr", 32'(mif.memAddr), 960);
      check("overrunSet", fetchOverrun, 1);
      waitFetchDone(3, 5000);
      check("overrunSticky", fetchOverrun, 1);
      enterDisplay(7);
      randomPixels(6);

      repeat (3) tick();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
